// File: rtl/ceespu_pkg.sv
// Shared data-memory definitions: access size codes used by execute/writeback and the
// bus bridge FSM state encoding.
package ceespu_pkg;

  localparam logic [1:0] MEM_WORD = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_BYTE = 2'd2;

  typedef enum logic {
    StIdle = 1'b0,
    StBus  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/ceespu_load_align.sv
// Lane extraction and sign/zero extension of a raw bus word for a load of word, half or byte
// size. Purely combinational; also used by the writeback stage.
module ceespu_load_align
  import ceespu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  sel_mem_i,
  output logic [31:0] data_o
);

  logic [15:0] half_lane;
  logic [7:0]  byte_lane;
  logic        zext;

  always_comb begin
    zext      = sel_mem_i[2];
    half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (offset_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase

    // Size code 3 is not a legal access size; it falls back to a full word.
    case (sel_mem_i[1:0])
      MEM_HALF: data_o = {{16{~zext & half_lane[15]}}, half_lane};
      MEM_BYTE: data_o = {{24{~zext & byte_lane[7]}}, byte_lane};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ceespu_dmem_bridge.sv
// Data-memory bridge: turns one execute-stage memory request into a single-beat req/ack bus
// cycle, stalls the pipeline until completion, and returns aligned load data or a timeout error.
module ceespu_dmem_bridge
  import ceespu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_memE,
  input  logic [3:0]        I_memWe,
  input  logic [31:0]       I_address,
  input  logic [31:0]       I_storeData,
  input  logic [2:0]        I_selMem,
  output logic              O_busy,
  output logic [31:0]       O_loadData,
  output logic              O_loadValid,
  output logic              O_error,
  output logic              O_busCyc,
  output logic              O_busWe,
  output logic [3:0]        O_busSel,
  output logic [ADDR_W-3:0] O_busAddr,
  output logic [31:0]       O_busWdata,
  input  logic [31:0]       I_busRdata,
  input  logic              I_busAck
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  bus_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        sel_mem_q, sel_mem_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic [31:0]       ldata_q, ldata_d;
  logic              lvalid_q, lvalid_d;
  logic              err_q, err_d;
  logic [31:0]       aligned;

  ceespu_load_align u_load_align (
    .rdata_i   (I_busRdata),
    .offset_i  (addr_q[1:0]),
    .sel_mem_i (sel_mem_q),
    .data_o    (aligned)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    sel_mem_d = sel_mem_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    we_d      = we_q;
    ldata_d   = ldata_q;
    lvalid_d  = 1'b0;
    err_d     = 1'b0;
    O_busy    = 1'b0;

    case (state_q)
      StIdle: begin
        O_busy = I_memE;
        if (I_memE) begin
          state_d   = StBus;
          cnt_d     = 8'd0;
          addr_d    = I_address[ADDR_W-1:0];
          sel_mem_d = I_selMem;
          wdata_d   = I_storeData;
          we_d      = |I_memWe;
          sel_d     = (|I_memWe) ? I_memWe : 4'hF;
        end
      end
      StBus: begin
        // Stall drops in the completion cycle so the pipeline advances on the ending edge.
        O_busy = ~I_busAck & (cnt_q != CntLast);
        if (I_busAck) begin
          state_d = StIdle;
          if (!we_q) begin
            lvalid_d = 1'b1;
            ldata_d  = aligned;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
          if (!we_q) begin
            lvalid_d = 1'b1;
            ldata_d  = 32'd0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      addr_q    <= '0;
      sel_mem_q <= 3'd0;
      wdata_q   <= 32'd0;
      sel_q     <= 4'd0;
      we_q      <= 1'b0;
      ldata_q   <= 32'd0;
      lvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      sel_mem_q <= sel_mem_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      ldata_q   <= ldata_d;
      lvalid_q  <= lvalid_d;
      err_q     <= err_d;
    end
  end

  assign O_busCyc    = (state_q == StBus);
  assign O_busWe     = we_q;
  assign O_busSel    = sel_q;
  assign O_busAddr   = addr_q[ADDR_W-1:2];
  assign O_busWdata  = wdata_q;
  assign O_loadData  = ldata_q;
  assign O_loadValid = lvalid_q;
  assign O_error     = err_q;

endmodule

// File: tb/tb_ceespu_dmem_bridge.sv
// Randomized self-checking bench for ceespu_dmem_bridge against a transaction-level model.
module tb_ceespu_dmem_bridge;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_e = 1'b0;
  logic [3:0]  mem_we = 4'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [2:0]  sel_mem = 3'd0;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_ack = 1'b0;

  logic        busy, load_valid, error, bus_cyc, bus_we;
  logic [31:0] load_data, bus_wdata;
  logic [3:0]  bus_sel;
  logic [29:0] bus_addr;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ld_model = 32'd0;

  ceespu_dmem_bridge #(
    .ADDR_W  (32),
    .TIMEOUT (T)
  ) dut (
    .I_clk       (clk),
    .I_rst       (rst),
    .I_memE      (mem_e),
    .I_memWe     (mem_we),
    .I_address   (address),
    .I_storeData (store_data),
    .I_selMem    (sel_mem),
    .O_busy      (busy),
    .O_loadData  (load_data),
    .O_loadValid (load_valid),
    .O_error     (error),
    .O_busCyc    (bus_cyc),
    .O_busWe     (bus_we),
    .O_busSel    (bus_sel),
    .O_busAddr   (bus_addr),
    .O_busWdata  (bus_wdata),
    .I_busRdata  (bus_rdata),
    .I_busAck    (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load result from the size/extension rules, using shift-and-mask arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [2:0] sm);
    int unsigned w, sh;
    logic [31:0] mask, v;
    case (sm[1:0])
      2'd1: begin w = 16; sh = addr[1] ? 16 : 0; end
      2'd2: begin w = 8;  sh = 8 * int'(addr[1:0]); end
      default: return rdata;
    endcase
    mask = (32'h1 << w) - 32'h1;
    v    = (rdata >> sh) & mask;
    if (!sm[2] && v[w-1]) v = v | ~mask;
    return v;
  endfunction

  // One request; ack_after = number of BUS cycles without ack before ack (negative: never).
  task automatic do_req(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] sm, input int ack_after, input logic [31:0] rdata);
    bit acked;
    @(negedge clk);
    mem_e      = 1'b1;
    mem_we     = we;
    address    = addr;
    store_data = wdata;
    sel_mem    = sm;
    bus_ack    = 1'b0;
    #1 check_eq("busy_request", busy, 1);
    acked = 1'b0;
    for (int k = 0; k < T; k++) begin
      @(negedge clk);
      check_eq("bus_cyc_active", bus_cyc, 1);
      check_eq("bus_addr", bus_addr, addr >> 2);
      check_eq("bus_sel", bus_sel, (we == 4'd0) ? 4'hF : we);
      check_eq("bus_we", bus_we, (we != 4'd0));
      check_eq("bus_wdata", bus_wdata, wdata);
      if (k == ack_after) begin
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        acked     = 1'b1;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
      end
      #1 check_eq("busy_bus", busy, (acked || k == T - 1) ? 0 : 1);
      if (acked || k == T - 1) break;
    end
    @(negedge clk);
    mem_e   = 1'b0;
    bus_ack = 1'b0;
    if (we == 4'd0) ld_model = acked ? ref_load(rdata, addr, sm) : 32'd0;
    check_eq("bus_cyc_done", bus_cyc, 0);
    check_eq("load_valid_pulse", load_valid, (we == 4'd0));
    check_eq("error_pulse", error, !acked);
    check_eq("load_data", load_data, ld_model);
    @(negedge clk);
    check_eq("load_valid_clear", load_valid, 0);
    check_eq("error_clear", error, 0);
    check_eq("load_data_hold", load_data, ld_model);
  endtask

  // Idle cycles with random stray acks, which must be ignored.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_ack   = 1'($urandom);
      bus_rdata = $urandom;
      #1;
      @(negedge clk);
      check_eq("idle_bus_cyc", bus_cyc, 0);
      check_eq("idle_load_valid", load_valid, 0);
      check_eq("idle_error", error, 0);
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_bus_cyc", bus_cyc, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_load_valid", load_valid, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_load_data", load_data, 0);
    check_eq("rst_bus_sel", bus_sel, 0);
    rst = 1'b0;

    do_req(4'd0, 32'h40, 32'd0, 3'd0, 3, 32'hDEADBEEF);
    do_req(4'd0, 32'h43, 32'd0, 3'd2, 0, 32'h80FF7F01);
    do_req(4'd0, 32'h43, 32'd0, 3'd6, 1, 32'h80FF7F01);
    do_req(4'd0, 32'h41, 32'd0, 3'd2, 2, 32'h80FF7F01);
    do_req(4'd0, 32'h42, 32'd0, 3'd1, 0, 32'h8001ABCD);
    do_req(4'd0, 32'h40, 32'd0, 3'd1, 0, 32'h8001ABCD);
    do_req(4'b0100, 32'h44, 32'h5A5A5A5A, 3'd2, 1, 32'h0);
    do_req(4'd0, 32'h80, 32'd0, 3'd0, -1, 32'h0);
    do_req(4'd0, 32'h80, 32'd0, 3'd0, T - 1, 32'h12345678);
    do_req(4'hF, 32'h84, 32'hCAFEF00D, 3'd0, -1, 32'h0);
    idle_gap(3);

    // Reset in the second BUS cycle of a load.
    @(negedge clk);
    mem_e   = 1'b1;
    mem_we  = 4'd0;
    address = 32'h100;
    sel_mem = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_mid_active", bus_cyc, 1);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    mem_e    = 1'b0;
    ld_model = 32'd0;
    check_eq("rst_mid_bus_cyc", bus_cyc, 0);
    check_eq("rst_mid_load_valid", load_valid, 0);
    check_eq("rst_mid_error", error, 0);
    @(negedge clk);
    check_eq("rst_mid_no_pulse", load_valid | error, 0);
    do_req(4'd0, 32'h104, 32'd0, 3'd0, 1, 32'h0BADF00D);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] we;
      we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      do_req(we, $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
